// File: rtl/traffic_pkg.sv
// Constants shared by the traffic-light controller and its sensor front ends.
package traffic_pkg;

    localparam int unsigned CLK_HZ = 10_000_000;

    localparam logic [1:0] RYG_RED    = 2'd0;
    localparam logic [1:0] RYG_YELLOW = 2'd1;
    localparam logic [1:0] RYG_GREEN  = 2'd2;

    localparam logic [2:0] VSC_IDLE     = 3'd0;
    localparam logic [2:0] VSC_QUALIFY  = 3'd1;
    localparam logic [2:0] VSC_WAITING  = 3'd2;
    localparam logic [2:0] VSC_SERVICED = 3'd3;
    localparam logic [2:0] VSC_STUCK    = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE     = VSC_IDLE,
        ST_QUALIFY  = VSC_QUALIFY,
        ST_WAITING  = VSC_WAITING,
        ST_SERVICED = VSC_SERVICED,
        ST_STUCK    = VSC_STUCK
    } vsc_state_e;

endpackage

// File: rtl/sync_debounce.sv
// Metastability synchroniser followed by a stable-level debouncer; dout only
// follows din after DEBOUNCE_CYCLES consecutive disagreeing samples.
module sync_debounce #(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 100000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic din,
    output logic dout
);

    localparam int unsigned     CW       = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CW-1:0]          cnt;
    logic                   synced;

    assign synced = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
            cnt    <= '0;
            dout   <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din};
            if (synced == dout) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                dout <= synced;
                cnt  <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/vehicle_sensor_conditioner.sv
// Secondary-road loop sensor front end: debounce, presence qualification,
// latched service request and stuck-sensor fail-safe for trafficLight.
module vehicle_sensor_conditioner
    import traffic_pkg::*;
#(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 100000,
    parameter int unsigned PRESENCE_CYCLES = 20000000,
    parameter int unsigned STUCK_CYCLES    = 32'd3000000000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       sensor_raw,
    input  logic       service_ack,
    output logic       vehicle_waiting,
    output logic       sensor_clean,
    output logic       sensor_fault,
    output logic [2:0] state_dbg
);

    localparam int unsigned   PW         = $clog2(PRESENCE_CYCLES + 1);
    localparam int unsigned   SW         = $clog2(STUCK_CYCLES + 1);
    localparam logic [PW-1:0] PRES_LAST  = PW'(PRESENCE_CYCLES - 1);
    localparam logic [SW-1:0] STUCK_LAST = SW'(STUCK_CYCLES - 1);

    vsc_state_e    state;
    logic [PW-1:0] pres_cnt;
    logic [SW-1:0] stuck_cnt;
    logic          pres_hit;
    logic          stuck_hit;

    assign pres_hit  = (pres_cnt == PRES_LAST);
    assign stuck_hit = sensor_clean && (stuck_cnt == STUCK_LAST);
    assign state_dbg = state;

    sync_debounce #(
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_sync_debounce (
        .clk     (clk),
        .reset_n (reset_n),
        .din     (sensor_raw),
        .dout    (sensor_clean)
    );

    // Saturates so a permanently occupied loop keeps asserting the fault.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            stuck_cnt <= '0;
        else if (!sensor_clean)
            stuck_cnt <= '0;
        else if (stuck_cnt != STUCK_LAST)
            stuck_cnt <= stuck_cnt + SW'(1);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state           <= ST_IDLE;
            pres_cnt        <= '0;
            vehicle_waiting <= 1'b0;
            sensor_fault    <= 1'b0;
        end else begin
            vehicle_waiting <= (state == ST_WAITING) || (state == ST_STUCK);
            sensor_fault    <= (state == ST_STUCK);
            if (state == ST_QUALIFY && !pres_hit)
                pres_cnt <= pres_cnt + PW'(1);

            if (stuck_hit && state != ST_STUCK) begin
                state <= ST_STUCK;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (sensor_clean) begin
                            state    <= ST_QUALIFY;
                            pres_cnt <= '0;
                        end
                    end
                    // A qualified vehicle wins over a same-cycle sensor drop.
                    ST_QUALIFY: begin
                        if (pres_hit)
                            state <= service_ack ? ST_SERVICED : ST_WAITING;
                        else if (!sensor_clean)
                            state <= ST_IDLE;
                    end
                    ST_WAITING: begin
                        if (service_ack)
                            state <= ST_SERVICED;
                    end
                    ST_SERVICED: begin
                        if (!service_ack) begin
                            if (sensor_clean) begin
                                state    <= ST_QUALIFY;
                                pres_cnt <= '0;
                            end else begin
                                state <= ST_IDLE;
                            end
                        end
                    end
                    ST_STUCK: begin
                        if (!sensor_clean)
                            state <= ST_IDLE;
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_vehicle_sensor_conditioner.sv
// Bench for vehicle_sensor_conditioner: directed timing scenarios plus a
// randomized run against a behavioural reference model.
module tb_vehicle_sensor_conditioner;
    import traffic_pkg::*;

    localparam int SYNC = 2;
    localparam int DEB  = 4;
    localparam int PRES = 8;
    localparam int STK  = 64;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       sensor_raw = 1'b0;
    logic       service_ack = 1'b0;
    logic       vehicle_waiting;
    logic       sensor_clean;
    logic       sensor_fault;
    logic [2:0] state_dbg;

    int n_checks = 0;
    int n_fail   = 0;

    vehicle_sensor_conditioner #(
        .SYNC_STAGES     (SYNC),
        .DEBOUNCE_CYCLES (DEB),
        .PRESENCE_CYCLES (PRES),
        .STUCK_CYCLES    (STK)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .sensor_raw      (sensor_raw),
        .service_ack     (service_ack),
        .vehicle_waiting (vehicle_waiting),
        .sensor_clean    (sensor_clean),
        .sensor_fault    (sensor_fault),
        .state_dbg       (state_dbg)
    );

    always #5 clk = ~clk;

    function automatic logic [5:0] outs();
        return {vehicle_waiting, sensor_clean, sensor_fault, state_dbg};
    endfunction

    function automatic logic [5:0] pk(input bit w, input bit c, input bit f, input logic [2:0] s);
        return {w, c, f, s};
    endfunction

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n     = 1'b0;
        sensor_raw  = 1'b0;
        service_ack = 1'b0;
        cyc(2);
        reset_n = 1'b1;
    endtask

    // Reference model: clean flips once the synchronised input has disagreed with it
    // for DEB consecutive samples; the phase follows the service rules.
    bit         m_hist[$];
    bit         m_clean, m_wait, m_fault;
    logic [2:0] m_phase;
    int         m_qual, m_high;

    task automatic model_reset();
        m_hist.delete();
        m_clean = 1'b0;
        m_wait  = 1'b0;
        m_fault = 1'b0;
        m_phase = VSC_IDLE;
        m_qual  = 0;
        m_high  = 0;
    endtask

    task automatic model_step(input bit raw, input bit ack);
        int         n;
        bit         flip, s, stuck;
        logic [2:0] nxt;
        n    = m_hist.size();
        flip = 1'b1;
        for (int j = 0; j < DEB; j++) begin
            if (n - j < SYNC) s = 1'b0;
            else s = m_hist[n - j - SYNC];
            if (n - j < 0 || s == m_clean) flip = 1'b0;
        end
        stuck = m_clean && (m_high >= STK - 1);
        nxt = m_phase;
        if (m_phase == VSC_STUCK) begin
            if (!m_clean) nxt = VSC_IDLE;
        end else if (stuck) begin
            nxt = VSC_STUCK;
        end else if (m_phase == VSC_IDLE) begin
            if (m_clean) nxt = VSC_QUALIFY;
        end else if (m_phase == VSC_QUALIFY) begin
            if (m_qual >= PRES - 1) nxt = ack ? VSC_SERVICED : VSC_WAITING;
            else if (!m_clean) nxt = VSC_IDLE;
        end else if (m_phase == VSC_WAITING) begin
            if (ack) nxt = VSC_SERVICED;
        end else if (!ack) begin
            nxt = m_clean ? VSC_QUALIFY : VSC_IDLE;
        end
        m_wait  = (m_phase == VSC_WAITING) || (m_phase == VSC_STUCK);
        m_fault = (m_phase == VSC_STUCK);
        m_qual  = (m_phase == VSC_QUALIFY && nxt == VSC_QUALIFY) ? m_qual + 1 : 0;
        m_high  = m_clean ? m_high + 1 : 0;
        m_phase = nxt;
        if (flip) m_clean = !m_clean;
        m_hist.push_back(raw);
    endtask

    task automatic test_reset();
        logic [5:0] exp;
        reset_n = 1'b0;
        #3;
        exp = pk(0, 0, 0, VSC_IDLE);
        n_checks++;
        if (outs() !== exp) begin n_fail++; $display("FAIL reset_hold: got %b want %b", outs(), exp); end
        do_reset();
        cyc(3);
        n_checks++;
        if (outs() !== exp) begin n_fail++; $display("FAIL reset_release: got %b want %b", outs(), exp); end
    endtask

    task automatic test_glitch();
        logic [5:0] exp;
        exp = pk(0, 0, 0, VSC_IDLE);
        do_reset();
        sensor_raw = 1'b1; cyc(1); sensor_raw = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cyc(1);
            n_checks++;
            if (outs() !== exp) begin n_fail++; $display("FAIL glitch_1clk t=%0d: got %b want %b", i, outs(), exp); end
        end
        sensor_raw = 1'b1; cyc(3); sensor_raw = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cyc(1);
            n_checks++;
            if (outs() !== exp) begin n_fail++; $display("FAIL glitch_3clk t=%0d: got %b want %b", i, outs(), exp); end
        end
    endtask

    task automatic test_qualify_ack();
        logic [5:0] exp;
        do_reset();
        sensor_raw = 1'b1;
        cyc(5); exp = pk(0, 0, 0, VSC_IDLE); n_checks++;
        if (outs() !== exp) begin n_fail++; $display("FAIL clean_early: got %b want %b", outs(), exp); end
        cyc(1); exp = pk(0, 1, 0, VSC_IDLE); n_checks++;
        if (outs() !== exp) begin n_fail++; $display("FAIL clean_at_6: got %b want %b", outs(), exp); end
        cyc(1); exp = pk(0, 1, 0, VSC_QUALIFY); n_checks++;
        if (outs() !== exp) begin n_fail++; $display("FAIL enter_qualify: got %b want %b", outs(), exp); end
        cyc(8); exp = pk(0, 1, 0, VSC_WAITING); n_checks++;
        if (outs() !== exp) begin n_fail++; $display("FAIL enter_waiting: got %b want %b", outs(), exp); end
        cyc(1); exp = pk(1, 1, 0, VSC_WAITING); n_checks++;
        if (outs() !== exp) begin n_fail++; $display("FAIL request_out: got %b want %b", outs(), exp); end
        service_ack = 1'b1; sensor_raw = 1'b0;
        cyc(1); exp = pk(1, 1, 0, VSC_SERVICED); n_checks++;
        if (outs() !== exp) begin n_fail++; $display("FAIL ack_taken: got %b want %b", outs(), exp); end
        cyc(1); exp = pk(0, 1, 0, VSC_SERVICED); n_checks++;
        if (outs() !== exp) begin n_fail++; $display("FAIL request_fall: got %b want %b", outs(), exp); end
        cyc(8); exp = pk(0, 0, 0, VSC_SERVICED); n_checks++;
        if (outs() !== exp) begin n_fail++; $display("FAIL serviced_hold: got %b want %b", outs(), exp); end
        service_ack = 1'b0;
        cyc(1); exp = pk(0, 0, 0, VSC_IDLE); n_checks++;
        if (outs() !== exp) begin n_fail++; $display("FAIL serviced_idle: got %b want %b", outs(), exp); end
    endtask

    task automatic test_latch();
        logic [5:0] exp;
        do_reset();
        sensor_raw = 1'b1;
        cyc(16); exp = pk(1, 1, 0, VSC_WAITING); n_checks++;
        if (outs() !== exp) begin n_fail++; $display("FAIL latch_req: got %b want %b", outs(), exp); end
        sensor_raw = 1'b0;
        for (int i = 0; i < 20; i++) begin
            cyc(1);
            n_checks++;
            if ({vehicle_waiting, state_dbg} !== {1'b1, VSC_WAITING}) begin
                n_fail++; $display("FAIL latch_hold t=%0d: got %b want %b", i, {vehicle_waiting, state_dbg}, {1'b1, VSC_WAITING});
            end
        end
        service_ack = 1'b1;
        cyc(1); exp = pk(1, 0, 0, VSC_SERVICED); n_checks++;
        if (outs() !== exp) begin n_fail++; $display("FAIL latch_ack: got %b want %b", outs(), exp); end
        cyc(1); exp = pk(0, 0, 0, VSC_SERVICED); n_checks++;
        if (outs() !== exp) begin n_fail++; $display("FAIL latch_fall: got %b want %b", outs(), exp); end
        service_ack = 1'b0;
        cyc(1); exp = pk(0, 0, 0, VSC_IDLE); n_checks++;
        if (outs() !== exp) begin n_fail++; $display("FAIL latch_idle: got %b want %b", outs(), exp); end
    endtask

    task automatic test_requeue();
        logic [5:0] exp;
        do_reset();
        sensor_raw = 1'b1;
        cyc(16); service_ack = 1'b1;
        cyc(10); exp = pk(0, 1, 0, VSC_SERVICED); n_checks++;
        if (outs() !== exp) begin n_fail++; $display("FAIL requeue_served: got %b want %b", outs(), exp); end
        service_ack = 1'b0;
        cyc(1); exp = pk(0, 1, 0, VSC_QUALIFY); n_checks++;
        if (outs() !== exp) begin n_fail++; $display("FAIL requeue_qualify: got %b want %b", outs(), exp); end
        cyc(7); n_checks++;
        if (outs() !== exp) begin n_fail++; $display("FAIL requeue_still_qual: got %b want %b", outs(), exp); end
        cyc(1); exp = pk(0, 1, 0, VSC_WAITING); n_checks++;
        if (outs() !== exp) begin n_fail++; $display("FAIL requeue_waiting: got %b want %b", outs(), exp); end
        cyc(1); exp = pk(1, 1, 0, VSC_WAITING); n_checks++;
        if (outs() !== exp) begin n_fail++; $display("FAIL requeue_request: got %b want %b", outs(), exp); end
    endtask

    task automatic test_stuck();
        logic [5:0] exp;
        do_reset();
        sensor_raw = 1'b1;
        cyc(69); exp = pk(1, 1, 0, VSC_WAITING); n_checks++;
        if (outs() !== exp) begin n_fail++; $display("FAIL stuck_before: got %b want %b", outs(), exp); end
        cyc(1); exp = pk(1, 1, 0, VSC_STUCK); n_checks++;
        if (outs() !== exp) begin n_fail++; $display("FAIL stuck_enter: got %b want %b", outs(), exp); end
        cyc(1); exp = pk(1, 1, 1, VSC_STUCK); n_checks++;
        if (outs() !== exp) begin n_fail++; $display("FAIL stuck_fault: got %b want %b", outs(), exp); end
        cyc(9); n_checks++;
        if (outs() !== exp) begin n_fail++; $display("FAIL stuck_hold: got %b want %b", outs(), exp); end
        sensor_raw = 1'b0;
        cyc(6); exp = pk(1, 0, 1, VSC_STUCK); n_checks++;
        if (outs() !== exp) begin n_fail++; $display("FAIL stuck_clean_low: got %b want %b", outs(), exp); end
        cyc(1); exp = pk(1, 0, 1, VSC_IDLE); n_checks++;
        if (outs() !== exp) begin n_fail++; $display("FAIL stuck_exit: got %b want %b", outs(), exp); end
        cyc(1); exp = pk(0, 0, 0, VSC_IDLE); n_checks++;
        if (outs() !== exp) begin n_fail++; $display("FAIL stuck_cleared: got %b want %b", outs(), exp); end
    endtask

    task automatic test_async_reset();
        logic [5:0] exp;
        do_reset();
        sensor_raw = 1'b1;
        cyc(16); exp = pk(1, 1, 0, VSC_WAITING); n_checks++;
        if (outs() !== exp) begin n_fail++; $display("FAIL areset_pre: got %b want %b", outs(), exp); end
        #2 reset_n = 1'b0;
        #1 exp = pk(0, 0, 0, VSC_IDLE); n_checks++;
        if (outs() !== exp) begin n_fail++; $display("FAIL areset_immediate: got %b want %b", outs(), exp); end
        sensor_raw = 1'b0;
        cyc(2);
        #2 reset_n = 1'b1;
        cyc(1); n_checks++;
        if (outs() !== exp) begin n_fail++; $display("FAIL areset_release: got %b want %b", outs(), exp); end
        cyc(3); n_checks++;
        if (outs() !== exp) begin n_fail++; $display("FAIL areset_settled: got %b want %b", outs(), exp); end
    endtask

    task automatic test_random();
        bit         raw, ack;
        int         raw_left, ack_left, errs;
        logic [5:0] exp;
        raw = 1'b0; ack = 1'b0; raw_left = 0; ack_left = 0; errs = 0;
        do_reset();
        model_reset();
        for (int c = 0; c < 3000; c++) begin
            if (c == 1500) begin
                do_reset();
                model_reset();
                raw = 1'b0; ack = 1'b0; raw_left = 0; ack_left = 0;
            end
            if (raw_left == 0) begin
                raw = !raw;
                raw_left = ($urandom_range(0, 7) == 0) ? int'($urandom_range(66, 90)) : int'($urandom_range(1, 14));
            end
            if (ack_left == 0) begin
                ack = ($urandom_range(0, 2) == 0);
                ack_left = int'($urandom_range(1, 12));
            end
            raw_left--;
            ack_left--;
            sensor_raw  = raw;
            service_ack = ack;
            @(posedge clk);
            model_step(raw, ack);
            #1;
            exp = pk(m_wait, m_clean, m_fault, m_phase);
            n_checks++;
            if (outs() !== exp) begin
                n_fail++; errs++;
                $display("FAIL random c=%0d: got w/c/f/st=%b want %b", c, outs(), exp);
            end
            if (errs >= 20) break;
        end
    endtask

    initial begin
        test_reset();
        test_glitch();
        test_qualify_ack();
        test_latch();
        test_requeue();
        test_stuck();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
